// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the IF/ID stall-controller state encoding.
package pipe_pkg;

    localparam logic [4:0]  OP_HALT   = 5'b00000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam int          IFID_W    = 33;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2,
        HALT   = 2'd3
    } state_t;

    function automatic logic [IFID_W-1:0] ifid_squash_word();
        return {1'b0, NOP_INSTR, 16'h0000};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register {valid, instr, pc_plus2}; squash overrides hold.
module ifid_reg
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              squash,
    input  logic [IFID_W-1:0] d,
    output logic [IFID_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= ifid_squash_word();
        end else if (squash) begin
            q <= ifid_squash_word();
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifid_stall_ctrl.sv
// Fetch/decode stall, flush and halt controller owning the IF/ID register and PC enable.
// Optional STALL_PERF_CNT_EN adds stall/flush performance counters.
module ifid_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MAX_STALL = 8,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        imem_rdy,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_plus2_in,
    output logic        pc_wr_en,
    output logic        idex_bubble,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted,
`ifdef STALL_PERF_CNT_EN
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt,
`endif
    output logic        stall_err
);

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               hold, squash, halt_det;
    logic [IFID_W-1:0]  ifid_q;

    assign ifid_valid    = ifid_q[32];
    assign ifid_instr    = ifid_q[31:16];
    assign ifid_pc_plus2 = ifid_q[15:0];

    assign halt_det = ifid_valid && (ifid_instr[15:11] == OP_HALT) && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    // The HALT word itself stays in IF/ID on the detect cycle so decode sees it frozen.
    always_comb begin
        state_nxt   = state_q;
        pc_wr_en    = 1'b0;
        idex_bubble = 1'b0;
        hold        = 1'b0;
        squash      = 1'b0;
        if (flush) begin
            pc_wr_en    = 1'b1;
            idex_bubble = 1'b1;
            squash      = 1'b1;
            state_nxt   = SQUASH;
        end else if (stall) begin
            idex_bubble = 1'b1;
            hold        = 1'b1;
            state_nxt   = HOLD;
        end else if (halted) begin
            hold        = 1'b1;
            state_nxt   = HALT;
        end else if (halt_det) begin
            pc_wr_en    = imem_rdy;
            hold        = 1'b1;
            state_nxt   = HALT;
        end else if (!imem_rdy) begin
            squash      = 1'b1;
            state_nxt   = RUN;
        end else begin
            pc_wr_en    = 1'b1;
            state_nxt   = RUN;
        end
    end

    ifid_reg u_ifid_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (hold),
        .squash (squash),
        .d      ({1'b1, instr_in, pc_plus2_in}),
        .q      (ifid_q)
    );

    always_comb begin
        cnt_nxt = '0;
        if (stall && !flush) begin
            cnt_nxt = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            halted    <= 1'b0;
            stall_err <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            if (flush) begin
                halted <= 1'b0;
            end else if (halt_det) begin
                halted <= 1'b1;
            end
            // Sticky once the run of stalls reaches the limit.
            if (stall && !flush && (cnt_nxt >= CNT_W'(MAX_STALL))) begin
                stall_err <= 1'b1;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 16'h0000;
            perf_flush_cnt <= 16'h0000;
        end else begin
            if (stall && !flush) begin
                perf_stall_cnt <= perf_stall_cnt + 16'h0001;
            end
            if (flush) begin
                perf_flush_cnt <= perf_flush_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule
